// File: rtl/rr_burst_scheduler_if.sv
// rr_burst_scheduler_if: request/beat handshake bundle for rr_burst_scheduler.
// master drives req/beat_ready; slave (scheduler) drives gnt/busy/beat_cnt/beat_last.
interface rr_burst_scheduler_if #(
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0] req;
   logic               beat_ready;
   logic [NUM_REQ-1:0] gnt;
   logic               busy;
   logic [1:0]         beat_cnt;
   logic               beat_last;

   modport master (
      output req, beat_ready,
      input  gnt, busy, beat_cnt, beat_last
   );

   modport slave (
      input  req, beat_ready,
      output gnt, busy, beat_cnt, beat_last
   );
endinterface

// File: rtl/rr_burst_scheduler.sv
// rr_burst_scheduler: round-robin burst grant in front of a shared 2-bit beat counter.
// Ports: clk, resetn (sync, active-low), bus (slave: req, beat_ready -> gnt, busy,
// beat_cnt, beat_last). Macro BURST_HANDOFF_EN: hand grant over at release with no bubble.
module rr_burst_scheduler #(
   parameter int NUM_REQ   = 4,
   parameter int MAX_BEATS = 3
) (
   input logic                  clk,
   input logic                  resetn,
   rr_burst_scheduler_if.slave  bus
);
   localparam int OW = $clog2(NUM_REQ);

   if (MAX_BEATS < 1 || MAX_BEATS > 3) begin : g_bad_beats
      $error("rr_burst_scheduler: MAX_BEATS must be 1..3");
   end
   if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_req
      $error("rr_burst_scheduler: NUM_REQ must be 2..8");
   end

   typedef enum logic {IDLE, GRANT} state_t;

   state_t             state, state_n;
   logic [NUM_REQ-1:0] gnt, gnt_n;
   logic [1:0]         cnt, cnt_n;
   logic [OW-1:0]      owner, owner_n;
   logic [OW-1:0]      last, last_n;
   logic               release_c;

   // First set bit searching upward from base+1, wrapping; base itself is last.
   function automatic logic [OW-1:0] rr_pick(
      input logic [NUM_REQ-1:0] r,
      input logic [OW-1:0]      base
   );
      logic [OW-1:0] sel;
      logic          found;
      sel   = base;
      found = 1'b0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         logic [OW-1:0] idx;
         idx = OW'((int'(base) + i) % NUM_REQ);
         if (!found && r[idx]) begin
            sel   = idx;
            found = 1'b1;
         end
      end
      return sel;
   endfunction

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state <= IDLE;
         gnt   <= '0;
         cnt   <= 2'd0;
         owner <= '0;
         last  <= OW'(NUM_REQ - 1);
      end else begin
         state <= state_n;
         gnt   <= gnt_n;
         cnt   <= cnt_n;
         owner <= owner_n;
         last  <= last_n;
      end
   end

   always_comb begin
      state_n   = state;
      gnt_n     = gnt;
      cnt_n     = cnt;
      owner_n   = owner;
      last_n    = last;
      release_c = 1'b0;
      unique case (state)
         IDLE: begin
            if (|bus.req) begin
               owner_n = rr_pick(bus.req, last);
               gnt_n   = NUM_REQ'(1) << owner_n;
               cnt_n   = 2'd0;
               state_n = GRANT;
            end
         end
         GRANT: begin
            // Owner dropping req wins over beat_ready: no beat is counted.
            if (!bus.req[owner]) begin
               release_c = 1'b1;
            end else if (bus.beat_ready) begin
               if (cnt == 2'(MAX_BEATS - 1)) release_c = 1'b1;
               else cnt_n = cnt + 2'd1;
            end
            if (release_c) begin
               gnt_n   = '0;
               cnt_n   = 2'd0;
               last_n  = owner;
               state_n = IDLE;
`ifdef BURST_HANDOFF_EN
               // Releasing owner is masked; if it is the sole requester the
               // normal IDLE bubble applies.
               if (|(bus.req & ~gnt)) begin
                  owner_n = rr_pick(bus.req & ~gnt, owner);
                  gnt_n   = NUM_REQ'(1) << owner_n;
                  state_n = GRANT;
               end
`endif
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign bus.gnt       = gnt;
   assign bus.busy      = (state == GRANT);
   assign bus.beat_cnt  = cnt;
   assign bus.beat_last = (state == GRANT) && (cnt == 2'(MAX_BEATS - 1));
endmodule

// File: tb/tb_rr_burst_scheduler.sv
// tb_rr_burst_scheduler: directed + random stimulus against a behavioural model.
// Checks gnt/busy/beat_cnt/beat_last every cycle, plus explicit scenario checks.
module tb_rr_burst_scheduler;
   localparam int N   = 4;
   localparam int MAX = 3;

   logic clk;
   logic resetn;
   int   checks;
   int   errors;

   // Model state: owner = -1 when nothing granted.
   int m_owner;
   int m_cnt;
   int m_last;

   rr_burst_scheduler_if #(.NUM_REQ(N)) bus ();

   rr_burst_scheduler #(.NUM_REQ(N), .MAX_BEATS(MAX)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int next_rr(input logic [N-1:0] r, input int base);
      for (int k = 1; k <= N; k++) begin
         int j;
         j = (base + k) % N;
         if (r[j]) return j;
      end
      return -1;
   endfunction

   task automatic model_update(input logic [N-1:0] r, input logic br, input logic rn);
      bit rel;
      logic [N-1:0] others;
      rel = 0;
      if (!rn) begin
         m_owner = -1;
         m_cnt   = 0;
         m_last  = N - 1;
      end else if (m_owner < 0) begin
         if (r != 0) begin
            m_owner = next_rr(r, m_last);
            m_cnt   = 0;
         end
      end else begin
         if (!r[m_owner]) rel = 1;
         else if (br) begin
            if (m_cnt == MAX - 1) rel = 1;
            else m_cnt = m_cnt + 1;
         end
         if (rel) begin
            m_last  = m_owner;
            m_cnt   = 0;
            m_owner = -1;
`ifdef BURST_HANDOFF_EN
            others = r;
            others[m_last] = 1'b0;
            if (others != 0) m_owner = next_rr(others, m_last);
`else
            others = '0;
`endif
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      logic [N-1:0] eg;
      eg = (m_owner < 0) ? '0 : (N'(1) << m_owner);
      chk("gnt", 32'(bus.gnt), 32'(eg));
      chk("busy", 32'(bus.busy), 32'(m_owner >= 0));
      chk("beat_cnt", 32'(bus.beat_cnt), 32'(m_cnt));
      chk("beat_last", 32'(bus.beat_last), 32'((m_owner >= 0) && (m_cnt == MAX - 1)));
   endtask

   task automatic cyc(input logic [N-1:0] r, input logic br, input logic rn);
      bus.req        = r;
      bus.beat_ready = br;
      resetn         = rn;
      @(posedge clk);
      model_update(r, br, rn);
      #1;
      check_model();
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      m_owner = -1;
      m_cnt   = 0;
      m_last  = N - 1;
      bus.req        = '0;
      bus.beat_ready = 1'b0;
      resetn         = 1'b0;

      // Reset with all requests pending.
      cyc(4'b1111, 1'b1, 1'b0);
      chk("rst_gnt0", 32'(bus.gnt), 32'h0);
      cyc(4'b1111, 1'b1, 1'b0);
      chk("rst_busy", 32'(bus.busy), 32'h0);
      chk("rst_cnt", 32'(bus.beat_cnt), 32'h0);
      cyc(4'b1111, 1'b1, 1'b1);
      chk("first_gnt", 32'(bus.gnt), 32'h1);

      // All requesting: rotating bursts.
      for (int i = 0; i < 18; i++) cyc(4'b1111, 1'b1, 1'b1);
      cyc(4'b0000, 1'b1, 1'b1);
      cyc(4'b0000, 1'b1, 1'b1);

      // Single requester: 3-beat bursts with a bubble.
      for (int i = 0; i < 9; i++) cyc(4'b0001, 1'b1, 1'b1);
      cyc(4'b0000, 1'b1, 1'b1);
      cyc(4'b0000, 1'b1, 1'b1);

      // Stall at beat_cnt=1 for 5 cycles.
      cyc(4'b0010, 1'b1, 1'b1);
      cyc(4'b0010, 1'b1, 1'b1);
      chk("stall_cnt_pre", 32'(bus.beat_cnt), 32'h1);
      for (int i = 0; i < 5; i++) begin
         cyc(4'b0010, 1'b0, 1'b1);
         chk("stall_gnt", 32'(bus.gnt), 32'h2);
      end
      cyc(4'b0010, 1'b1, 1'b1);
      chk("stall_last", 32'(bus.beat_last), 32'h1);
      cyc(4'b0000, 1'b1, 1'b1);
      chk("stall_done", 32'(bus.gnt), 32'h0);

      // Owner drops after one beat.
      cyc(4'b1100, 1'b1, 1'b1);
      cyc(4'b1100, 1'b1, 1'b1);
      cyc(4'b1000, 1'b1, 1'b1);
      chk("drop_cnt", 32'(bus.beat_cnt), 32'h0);
      for (int i = 0; i < 4; i++) cyc(4'b1000, 1'b1, 1'b1);
      cyc(4'b0000, 1'b0, 1'b1);

      // Reset mid-burst at beat_cnt=2 with gnt=0100.
      cyc(4'b0000, 1'b0, 1'b1);
      cyc(4'b0100, 1'b1, 1'b1);
      cyc(4'b0100, 1'b1, 1'b1);
      cyc(4'b0100, 1'b1, 1'b1);
      chk("pre_rst_gnt", 32'(bus.gnt), 32'h4);
      chk("pre_rst_cnt", 32'(bus.beat_cnt), 32'h2);
      cyc(4'b0101, 1'b1, 1'b0);
      chk("mid_rst_gnt", 32'(bus.gnt), 32'h0);
      chk("mid_rst_cnt", 32'(bus.beat_cnt), 32'h0);
      cyc(4'b0101, 1'b1, 1'b1);
      chk("post_rst_gnt", 32'(bus.gnt), 32'h1);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         logic [N-1:0] r;
         logic br;
         logic rn;
         r  = N'($urandom);
         br = ($urandom_range(0, 9) < 7);
         rn = ($urandom_range(0, 63) != 0);
         cyc(r, br, rn);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
